line_mem_responder: RTL and testbench

Memory-side responder for the cache controller's line refill and write-back protocol. It accepts one line request at a time, waits a programmable access latency, then either streams a full cache line of 32-bit words back with a valid/ready handshake or absorbs a full line of write data. It backs a word-addressed storage array and sits between the cache controller and the top-level memory map; it serves as both the simulation main memory and the synthesizable on-chip RAM.

---
 rtl/line_mem_responder.sv | 176 +++++++++++++++++
 tb/tb_line_mem_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line_mem_responder.sv
// ============================================================================
// Module   : line_mem_responder
// Brief    : Memory-side line responder for cache refill and write-back.
//            Optional range check is enabled by MEMRSP_RANGE_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_mem_responder #(
    parameter int LINE_WORDS  = 4,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iREQ_VALID,
    output logic        oREQ_READY,
    input  logic        iREQ_WE,
    input  logic [31:0] iREQ_ADDR,
    output logic [31:0] oRDATA,
    output logic        oRVALID,
    output logic        oRLAST,
    input  logic        iRREADY,
    input  logic [31:0] iWDATA,
    input  logic        iWVALID,
    output logic        oWREADY,
    output logic        oWACK,
    output logic        oERR
);

    localparam int c_OFF_W  = $clog2(LINE_WORDS);
    localparam int c_ADDR_W = $clog2(DEPTH_WORDS);
    // WAIT lasts LATENCY cycles and exits when the counter reads zero.
    localparam logic [3:0] c_LAT_LOAD = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_RBURST = 3'd2,
        S_WBURST = 3'd3,
        S_WACK   = 3'd4
`ifdef MEMRSP_RANGE_CHECK_EN
        , S_ERR  = 3'd5
`endif
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic [c_ADDR_W-1:0] r_baseIdx;
    logic [c_ADDR_W-1:0] w_reqIdx;
    logic [c_ADDR_W-1:0] w_memAddr;
    logic                r_we;
    logic [c_OFF_W-1:0]  r_beatCnt;
    logic [3:0]          r_latCnt;
    logic                w_lastBeat;
    logic                w_reqBad;
    logic                w_unusedAddr;
    logic [31:0]         r_mem [0:DEPTH_WORDS-1];

    assign w_reqIdx     = iREQ_ADDR[c_ADDR_W+1:2] & ~c_ADDR_W'(LINE_WORDS - 1);
    assign w_memAddr    = r_baseIdx | c_ADDR_W'(r_beatCnt);
    assign w_lastBeat   = (r_beatCnt == c_OFF_W'(LINE_WORDS - 1));
    assign w_unusedAddr = ^{iREQ_ADDR[1:0], iREQ_ADDR[31:c_ADDR_W+2]};

`ifdef MEMRSP_RANGE_CHECK_EN
    assign w_reqBad = (iREQ_ADDR >= 32'(4 * DEPTH_WORDS));
`else
    assign w_reqBad = 1'b0;
`endif

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state   <= S_IDLE;
            r_baseIdx <= '0;
            r_we      <= 1'b0;
            r_beatCnt <= '0;
            r_latCnt  <= '0;
        end else begin
            r_state <= w_stateNext;
            case (r_state)
                S_IDLE: begin
                    if (iREQ_VALID) begin
                        r_baseIdx <= w_reqIdx;
                        r_we      <= iREQ_WE;
                        r_beatCnt <= '0;
                        r_latCnt  <= c_LAT_LOAD;
                    end
                end
                S_WAIT: begin
                    if (r_latCnt != 4'd0) begin
                        r_latCnt <= r_latCnt - 4'd1;
                    end
                end
                S_RBURST: begin
                    if (iRREADY) begin
                        r_beatCnt <= r_beatCnt + 1'b1;
                    end
                end
                S_WBURST: begin
                    if (iWVALID) begin
                        r_beatCnt <= r_beatCnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge iCLK) begin
        if (r_state == S_WBURST && iWVALID) begin
            r_mem[w_memAddr] <= iWDATA;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        oREQ_READY  = 1'b0;
        oRVALID     = 1'b0;
        oRLAST      = 1'b0;
        oRDATA      = '0;
        oWREADY     = 1'b0;
        oWACK       = 1'b0;
        oERR        = 1'b0;
        case (r_state)
            S_IDLE: begin
                oREQ_READY = 1'b1;
                if (iREQ_VALID) begin
`ifdef MEMRSP_RANGE_CHECK_EN
                    if (w_reqBad) begin
                        w_stateNext = S_ERR;
                    end else
`endif
                    if (LATENCY == 0) begin
                        w_stateNext = iREQ_WE ? S_WBURST : S_RBURST;
                    end else begin
                        w_stateNext = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_latCnt == 4'd0) begin
                    w_stateNext = r_we ? S_WBURST : S_RBURST;
                end
            end
            S_RBURST: begin
                oRVALID = 1'b1;
                oRLAST  = w_lastBeat;
                oRDATA  = r_mem[w_memAddr];
                if (iRREADY && w_lastBeat) begin
                    w_stateNext = S_IDLE;
                end
            end
            S_WBURST: begin
                oWREADY = 1'b1;
                if (iWVALID && w_lastBeat) begin
                    w_stateNext = S_WACK;
                end
            end
            S_WACK: begin
                oWACK       = 1'b1;
                w_stateNext = S_IDLE;
            end
`ifdef MEMRSP_RANGE_CHECK_EN
            S_ERR: begin
                oERR        = 1'b1;
                w_stateNext = S_IDLE;
            end
`endif
            default: w_stateNext = S_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_line_mem_responder.sv
// ============================================================================
// Module   : tb_line_mem_responder
// Brief    : Self-checking bench for line_mem_responder against a word-array model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_mem_responder;

    localparam int LW    = 4;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqWe = 1'b0;
    logic [31:0] reqAddr = '0;
    logic        rready = 1'b0;
    logic [31:0] wdata = '0;
    logic        wvalid = 1'b0;
    logic        reqReady, rvalid, rlast, wready, wack, err;
    logic [31:0] rdata;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl [DEPTH];
    int          lines[$];

    line_mem_responder #(
        .LINE_WORDS (LW),
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .iCLK      (clk),
        .iRST      (rst),
        .iREQ_VALID(reqValid),
        .oREQ_READY(reqReady),
        .iREQ_WE   (reqWe),
        .iREQ_ADDR (reqAddr),
        .oRDATA    (rdata),
        .oRVALID   (rvalid),
        .oRLAST    (rlast),
        .iRREADY   (rready),
        .iWDATA    (wdata),
        .iWVALID   (wvalid),
        .oWREADY   (wready),
        .oWACK     (wack),
        .oERR      (err)
    );

    always #5 clk = ~clk;

    function automatic int lineBase(logic [31:0] a);
        int idx;
        idx = int'((a >> 2) % DEPTH);
        return idx & ~(LW - 1);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdleOutputs(string tag);
        chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
        chk({tag, "_rlast"},  32'(rlast),  32'd0);
        chk({tag, "_rdata"},  rdata,       32'd0);
        chk({tag, "_wready"}, 32'(wready), 32'd0);
        chk({tag, "_wack"},   32'(wack),   32'd0);
        chk({tag, "_err"},    32'(err),    32'd0);
    endtask

    // Present a request, hold it until accepted; returns in the cycle after acceptance.
    task automatic issue(logic we, logic [31:0] addr);
        int n = 0;
        reqValid = 1'b1;
        reqWe    = we;
        reqAddr  = addr;
        while (!reqReady && n < 200) begin
            tick();
            n++;
        end
        chk("reqReadyWait", 32'(reqReady), 32'd1);
        tick();
        reqValid = 1'b0;
        reqWe    = 1'($urandom);
        reqAddr  = $urandom;
    endtask

    task automatic waitLatency(logic we);
        int n = 0;
        while (!(we ? wready : rvalid) && n < 50) begin
            tick();
            n++;
        end
        chk(we ? "wLatency" : "rLatency", 32'(n), 32'(LAT));
    endtask

    task automatic writeLine(logic [31:0] addr, bit fixedData, bit bubbles);
        int base;
        int i = 0;
        int n = 0;
        base = lineBase(addr);
        issue(1'b1, addr);
        waitLatency(1'b1);
        while (i < LW && n < 200) begin
            wvalid = bubbles ? ((n % 2) == 0) : 1'b1;
            wdata  = fixedData ? 32'(32'h11 * (i + 1)) : $urandom;
            chk("wready", 32'(wready), 32'd1);
            chk("wackEarly", 32'(wack), 32'd0);
            tick();
            if (wvalid) begin
                mdl[base + i] = wdata;
                i++;
            end
            n++;
        end
        wvalid = 1'b0;
        wdata  = $urandom;
        chk("wack", 32'(wack), 32'd1);
        chk("wreadyOff", 32'(wready), 32'd0);
        tick();
        chk("wackOnce", 32'(wack), 32'd0);
        chk("reqReadyAfterW", 32'(reqReady), 32'd1);
    endtask

    // stallMode: 0 none, 1 hold beat 1 for 3 cycles, 2 random backpressure.
    task automatic readLine(logic [31:0] addr, int stallMode, int resetAtBeat);
        int base;
        int i = 0;
        int n = 0;
        int stalls = 0;
        base = lineBase(addr);
        issue(1'b0, addr);
        waitLatency(1'b0);
        while (i < LW && n < 300) begin
            if (i == resetAtBeat) begin
                rst = 1'b1;
                #1;
                checkIdleOutputs("midReset");
                chk("midResetReady", 32'(reqReady), 32'd1);
                tick();
                rst    = 1'b0;
                rready = 1'b0;
                tick();
                chk("readyAfterReset", 32'(reqReady), 32'd1);
                checkIdleOutputs("afterReset");
                return;
            end
            if (stallMode == 1) begin
                rready = !(i == 1 && stalls < 3);
                if (!rready) stalls++;
            end else if (stallMode == 2) begin
                rready = ($urandom % 3) != 0;
            end else begin
                rready = 1'b1;
            end
            chk("rvalid", 32'(rvalid), 32'd1);
            chk("rdata", rdata, mdl[base + i]);
            chk("rlast", 32'(rlast), 32'(i == LW - 1));
            tick();
            if (rready) i++;
            n++;
        end
        rready = 1'b0;
        chk("rvalidOff", 32'(rvalid), 32'd0);
        chk("reqReadyAfterR", 32'(reqReady), 32'd1);
        if (stallMode == 0) chk("rBeatCycles", 32'(n), 32'(LW));
        if (stallMode == 1) chk("rStallCycles", 32'(n), 32'(LW + 3));
    endtask

    initial begin
        logic [31:0] a;
        #2;
        rst = 1'b1;
        #1;
        checkIdleOutputs("reset");
        chk("resetReady", 32'(reqReady), 32'd1);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("readyAfterRelease", 32'(reqReady), 32'd1);

        writeLine(32'h40, 1'b1, 1'b0);
        readLine(32'h40, 0, -1);
        readLine(32'h40, 1, -1);

        writeLine(32'h80, 1'b0, 1'b1);
        readLine(32'h80, 0, -1);

        readLine(32'h4C, 0, -1);

        writeLine(32'h0, 1'b0, 1'b0);
        readLine(32'h40, 0, 2);
        readLine(32'h40, 0, -1);

`ifdef MEMRSP_RANGE_CHECK_EN
        issue(1'b0, 32'h1000);
        chk("errPulse", 32'(err), 32'd1);
        chk("errNoRvalid", 32'(rvalid), 32'd0);
        tick();
        chk("errOnce", 32'(err), 32'd0);
        chk("errNoRvalid2", 32'(rvalid), 32'd0);
        chk("errReady", 32'(reqReady), 32'd1);
        readLine(32'h0, 0, -1);
`else
        readLine(32'h1000, 0, -1);
`endif

        repeat (12) begin
`ifdef MEMRSP_RANGE_CHECK_EN
            a = $urandom % (4 * DEPTH);
`else
            a = $urandom;
`endif
            writeLine(a, 1'b0, 1'($urandom));
            lines.push_back(lineBase(a));
        end
        repeat (12) begin
            a = 32'(lines[$urandom_range(0, lines.size() - 1)] * 4) | ($urandom & 32'hF);
`ifndef MEMRSP_RANGE_CHECK_EN
            a = a | ($urandom & 32'hFFFF_F000);
`endif
            readLine(a, 2, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
